// File: rtl/alu_seq_if.sv
// Request/response bundle between the control logic and the wide ALU sequencer.
// The master issues requests and consumes responses; the slave is the sequencer.
interface alu_seq_if #(
    parameter int SLICES = 4
) ();
    localparam int W = 4 * SLICES;

    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_f;
    logic         rsp_zero;
    logic         rsp_over;
    logic         rsp_cout;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_f, rsp_zero, rsp_over, rsp_cout
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_f, rsp_zero, rsp_over, rsp_cout
    );
endinterface

// File: rtl/alu_seq.sv
// Wide ALU sequencer: runs a 4-bit slice over SLICES nibbles, LSB first,
// carrying between slices and deriving wide zero/overflow/carry flags.
module alu_seq #(
    parameter int SLICES = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus,
    output logic     busy
);
    localparam int W    = 4 * SLICES;
    localparam int IDXW = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SLICES - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_LT  = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Sub, less-than and equal all work on a - b, i.e. a + ~b + 1.
    function automatic logic is_sub_mode(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_LT) || (op == OP_EQ);
    endfunction

    logic [1:0]      state_reg;
    logic [2:0]      op_reg;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [IDXW-1:0] idx_reg;
    logic            carry_reg;
    logic [W-1:0]    acc_reg;
    logic [W-1:0]    rsp_f_reg;
    logic            rsp_zero_reg;
    logic            rsp_over_reg;
    logic            rsp_cout_reg;

    logic [3:0]   a_nib;
    logic [3:0]   b_nib;
    logic [3:0]   xb_nib;
    logic [4:0]   sum5;
    logic [3:0]   res_nib;
    logic         sub_mode;
    logic [W-1:0] acc_next;
    logic         over_w;
    logic         less_w;
    logic [W-1:0] fin_f;
    logic         fin_over;
    logic         fin_cout;

    // Select the operand nibbles addressed by the current slice index.
    always_comb begin
        a_nib = 4'h0;
        b_nib = 4'h0;
        for (int i = 0; i < SLICES; i++) begin
            if (idx_reg == IDXW'(i)) begin
                a_nib = a_reg[i*4 +: 4];
                b_nib = b_reg[i*4 +: 4];
            end
        end
    end

    // One 4-bit ALU slice: adder with conditional b inversion plus logic ops.
    always_comb begin
        sub_mode = is_sub_mode(op_reg);
        xb_nib   = b_nib ^ {4{sub_mode}};
        sum5     = {1'b0, a_nib} + {1'b0, xb_nib} + {4'b0000, carry_reg};
        case (op_reg)
            OP_NOT:  res_nib = ~a_nib;
            OP_AND:  res_nib = a_nib & b_nib;
            OP_OR:   res_nib = a_nib | b_nib;
            OP_XOR:  res_nib = a_nib ^ b_nib;
            default: res_nib = sum5[3:0];
        endcase
    end

    // Accumulator with the current slice's nibble merged in; on the last
    // slice this is the complete wide result (or the difference for lt/eq).
    generate
        for (genvar gi = 0; gi < SLICES; gi++) begin : g_acc
            assign acc_next[gi*4 +: 4] = (idx_reg == IDXW'(gi)) ? res_nib
                                                                : acc_reg[gi*4 +: 4];
        end
    endgenerate

    // Wide flags from the MSB slice and the op-dependent final result.
    always_comb begin
        over_w   = (a_nib[3] == xb_nib[3]) && (sum5[3] != a_nib[3]);
        less_w   = sum5[3] ^ over_w;
        fin_f    = acc_next;
        fin_over = 1'b0;
        fin_cout = 1'b0;
        case (op_reg)
            OP_ADD, OP_SUB: begin
                fin_over = over_w;
                fin_cout = sum5[4];
            end
            OP_LT:   fin_f = W'(less_w);
            OP_EQ:   fin_f = W'(acc_next == '0);
            default: fin_f = acc_next;
        endcase
    end

    // Sequencer state: accept, run one slice per clock, then hold the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            op_reg       <= 3'b000;
            a_reg        <= '0;
            b_reg        <= '0;
            idx_reg      <= '0;
            carry_reg    <= 1'b0;
            acc_reg      <= '0;
            rsp_f_reg    <= '0;
            rsp_zero_reg <= 1'b0;
            rsp_over_reg <= 1'b0;
            rsp_cout_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        op_reg    <= bus.req_op;
                        a_reg     <= bus.req_a;
                        b_reg     <= bus.req_b;
                        idx_reg   <= '0;
                        carry_reg <= is_sub_mode(bus.req_op);
                        acc_reg   <= '0;
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    carry_reg <= sum5[4];
                    acc_reg   <= acc_next;
                    if (idx_reg == LAST_IDX) begin
                        rsp_f_reg    <= fin_f;
                        rsp_zero_reg <= (fin_f == '0);
                        rsp_over_reg <= fin_over;
                        rsp_cout_reg <= fin_cout;
                        state_reg    <= ST_DONE;
                    end else begin
                        idx_reg <= idx_reg + IDXW'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.rsp_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state_reg == ST_IDLE);
    assign bus.rsp_valid = (state_reg == ST_DONE);
    assign bus.rsp_f     = rsp_f_reg;
    assign bus.rsp_zero  = rsp_zero_reg;
    assign bus.rsp_over  = rsp_over_reg;
    assign bus.rsp_cout  = rsp_cout_reg;
    assign busy          = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed corner cases, backpressure, async reset and
// random operations checked against a whole-word arithmetic model.
module tb_alu_seq;
    localparam int SLICES = 4;
    localparam int W      = 4 * SLICES;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_LT  = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    alu_seq_if #(.SLICES(SLICES)) bus ();

    alu_seq #(.SLICES(SLICES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] exp_f;
    logic         exp_zero;
    logic         exp_over;
    logic         exp_cout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word integer arithmetic, no nibble decomposition.
    function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint ua   = longint'(a);
        longint ub   = longint'(b);
        longint sa   = longint'($signed(a));
        longint sb   = longint'($signed(b));
        longint smax = (longint'(1) << (W - 1)) - 1;
        longint smin = -smax - 1;
        longint umax = (longint'(1) << W) - 1;
        longint r;
        exp_over = 1'b0;
        exp_cout = 1'b0;
        case (op)
            OP_ADD: begin
                exp_f    = W'(ua + ub);
                exp_cout = (ua + ub) > umax;
                r        = sa + sb;
                exp_over = (r > smax) || (r < smin);
            end
            OP_SUB: begin
                exp_f    = W'(ua - ub);
                exp_cout = (ua >= ub);
                r        = sa - sb;
                exp_over = (r > smax) || (r < smin);
            end
            OP_NOT:  exp_f = ~a;
            OP_AND:  exp_f = a & b;
            OP_OR:   exp_f = a | b;
            OP_XOR:  exp_f = a ^ b;
            OP_LT:   exp_f = (sa < sb) ? W'(1) : W'(0);
            default: exp_f = (a == b) ? W'(1) : W'(0);
        endcase
        exp_zero = (exp_f == '0);
    endfunction

    // Present one request while idle; returns #1 after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        chk("req_ready_before_issue", bus.req_ready, 1);
        model(op, a, b);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'($urandom);
        bus.req_a     = W'($urandom);
        bus.req_b     = W'($urandom);
    endtask

    // Count edges until rsp_valid, then compare the response against the model.
    task automatic wait_done(input string tag);
        int lat = 0;
        int ready_seen = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 20) begin
            if (bus.req_ready !== 1'b0) ready_seen++;
            @(posedge clk);
            #1;
            lat++;
        end
        chk($sformatf("%s latency", tag), lat, SLICES);
        chk($sformatf("%s ready_in_run", tag), ready_seen, 0);
        chk($sformatf("%s f", tag), bus.rsp_f, exp_f);
        chk($sformatf("%s flags", tag), {bus.rsp_zero, bus.rsp_over, bus.rsp_cout},
            {exp_zero, exp_over, exp_cout});
        chk($sformatf("%s busy_done", tag), {busy, bus.req_ready}, 2'b10);
    endtask

    task automatic release_rsp(input string tag);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        chk($sformatf("%s back_to_idle", tag), {bus.rsp_valid, bus.req_ready, busy}, 3'b010);
    endtask

    logic [W-1:0] corner [6];

    initial begin
        int seen;
        logic [2:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        corner[0] = '0;
        corner[1] = '1;
        corner[2] = W'(1);
        corner[3] = {1'b1, {(W-1){1'b0}}};
        corner[4] = {1'b0, {(W-1){1'b1}}};
        corner[5] = W'(16'h1234);

        bus.req_valid = 1'b0;
        bus.req_op    = 3'b000;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", {bus.rsp_valid, busy, bus.rsp_zero, bus.rsp_over, bus.rsp_cout}, 5'b0);
        chk("reset rsp_f", bus.rsp_f, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after reset idle", {bus.req_ready, busy}, 2'b10);

        // Directed corner cases (first one with rsp_ready held high)
        bus.rsp_ready = 1'b1;
        issue(OP_ADD, 16'h7FFF, 16'h0001); wait_done("add_7fff_1"); release_rsp("add_7fff_1");
        issue(OP_SUB, 16'h0005, 16'h0005); wait_done("sub_5_5");    release_rsp("sub_5_5");
        issue(OP_SUB, 16'h8000, 16'h0001); wait_done("sub_8000_1"); release_rsp("sub_8000_1");
        issue(OP_LT,  16'hFFFF, 16'h0001); wait_done("lt_m1_1");    release_rsp("lt_m1_1");
        issue(OP_LT,  16'h0001, 16'hFFFF); wait_done("lt_1_m1");    release_rsp("lt_1_m1");
        issue(OP_EQ,  16'h1234, 16'h1234); wait_done("eq_same");    release_rsp("eq_same");
        issue(OP_EQ,  16'h1234, 16'h1235); wait_done("eq_diff");    release_rsp("eq_diff");
        issue(OP_XOR, 16'hA5A5, 16'hFFFF); wait_done("xor");        release_rsp("xor");
        issue(OP_NOT, 16'hFFFF, 16'h1234); wait_done("not");        release_rsp("not");
        issue(OP_AND, 16'hF0F0, 16'h3C3C); wait_done("and");        release_rsp("and");
        issue(OP_OR,  16'h0F00, 16'h00F0); wait_done("or");         release_rsp("or");
        issue(OP_ADD, 16'hFFFF, 16'h0001); wait_done("add_carry");  release_rsp("add_carry");

        // Backpressure in DONE with a request waiting
        issue(OP_SUB, 16'h1234, 16'h4321); wait_done("bp");
        bus.req_valid = 1'b1;
        bus.req_op    = OP_OR;
        bus.req_a     = 16'h00F0;
        bus.req_b     = 16'h0F00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp hold%0d f", i), bus.rsp_f, exp_f);
            chk($sformatf("bp hold%0d ctl", i),
                {bus.rsp_valid, bus.req_ready, busy, bus.rsp_zero, bus.rsp_over, bus.rsp_cout},
                {3'b101, exp_zero, exp_over, exp_cout});
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        chk("bp release idle", {bus.rsp_valid, bus.req_ready, busy}, 3'b010);
        model(OP_OR, 16'h00F0, 16'h0F00);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("bp next accepted", {busy, bus.req_ready}, 2'b10);
        wait_done("bp_next"); release_rsp("bp_next");

        // Randomized operations
        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : W'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : W'($urandom);
            if ($urandom_range(0, 5) == 0) rb = ra;
            issue(rop, ra, rb);
            wait_done($sformatf("rnd%0d op%0d %h %h", n, rop, ra, rb));
            release_rsp($sformatf("rnd%0d", n));
        end

        // Async reset in the middle of RUN
        issue(OP_ADD, 16'h8000, 16'h8000); wait_done("pre_reset"); release_rsp("pre_reset");
        issue(OP_ADD, 16'h1111, 16'h2222);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset ctl",
            {bus.rsp_valid, busy, bus.rsp_zero, bus.rsp_over, bus.rsp_cout}, 5'b0);
        chk("async reset f", bus.rsp_f, 0);
        seen = 0;
        repeat (3) begin
            @(posedge clk);
            if (bus.rsp_valid === 1'b1) seen++;
        end
        #3;
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid !== 1'b0) seen++;
        end
        chk("no rsp after reset", seen, 0);
        chk("ready after reset", {bus.req_ready, busy}, 2'b10);
        issue(OP_ADD, 16'h0001, 16'h0001); wait_done("post_reset"); release_rsp("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Multi-cycle sequencer that drives one 4-bit ALU slice to execute wide (4*SLICES-bit) operations, one nibble per clock, LSB first.
- Carries the inter-slice carry, accumulates result nibbles, and derives the wide zero, overflow and carry flags.
- Requests use a valid/ready handshake; responses use a valid/ready handshake. It sits between the instruction/control logic and the ALU datapath.

Parameters:
- SLICES, 4, number of 4-bit slices; operand width W = 4*SLICES (16 by default); must be >= 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  3  operation code: 000 add, 001 sub, 010 not a, 011 and, 100 or, 101 xor, 110 signed less-than, 111 equal.
- req_a  in  W  operand a.
- req_b  in  W  operand b.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_f  out  W  result.
- rsp_zero  out  1  rsp_f == 0.
- rsp_over  out  1  signed overflow (add/sub only).
- rsp_cout  out  1  carry out of the MSB (add/sub only; for sub, 1 = no borrow).
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE; slice index = 0; internal registers cleared.
  - req_ready = 1 once rst_n deasserts.
  - rsp_valid = 0, rsp_f = 0, all flags = 0, busy = 0.
  - Reset asserted mid-operation discards the in-flight operation; no response is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - req_ready = 1.
  - When req_valid is high at a rising edge:
    - latch op, a and b;
    - idx = 0;
    - carry = 1 for sub/less/equal, else 0;
    - go to RUN.
  - Inputs are sampled only at this accept edge.
- RUN:
  - req_ready = 0.
  - Each edge processes nibble idx:
    - xb = b_nib XOR {4{sub_mode}}, where sub_mode is set for sub, less and equal;
    - {c, s} = a_nib + xb + carry; carry <= c;
    - the result nibble depends on op (sum, ~a, a&b, a|b or a^b);
    - store the result nibble; idx++.
  - On the edge that processes idx = SLICES-1, compute the flags and go to DONE.
  - Logic ops also take the full SLICES cycles, giving a uniform latency.
- Flag computation (from the MSB slice):
  - over = (a_msb == xb_msb) && (sum_msb != a_msb);
  - cout = final carry;
  - less = sum_msb XOR over.
- Result by op:
  - add, sub: rsp_f is the full sum; rsp_over and rsp_cout are valid.
  - less: rsp_f = {0..., less}.
  - equal: rsp_f = {0..., (difference == 0)}.
  - Logic ops and less/equal: rsp_over = rsp_cout = 0.
  - All ops: rsp_zero = (rsp_f == 0).
- DONE:
  - rsp_valid = 1; rsp_f and flags are registered and held stable until rsp_ready is high at an edge.
  - On that edge, rsp_valid drops and the state goes to IDLE.
  - No new request is accepted in DONE, even if rsp_ready and req_valid are high together.
- Latency: rsp_valid is high in the cycle after the SLICES-th edge following the accept edge (4 edges by default).
- Maximum throughput: one operation per SLICES+2 cycles.
- Outputs in IDLE/RUN: rsp_f and flags keep their last response values; they are defined only while rsp_valid = 1.
- Wrap-around: the slice index saturates at SLICES-1. Overflow and carry out are reported, never trapped.

Test Plan:
- Add 0x7FFF + 0x0001, rsp_ready held high -> rsp_valid exactly 4 edges after accept; rsp_f = 0x8000; over = 1, cout = 0, zero = 0.
- Sub 0x0005 - 0x0005 -> rsp_f = 0x0000, zero = 1, cout = 1, over = 0. Sub 0x8000 - 0x0001 -> rsp_f = 0x7FFF, over = 1, cout = 1.
- Less 0xFFFF vs 0x0001 -> rsp_f = 0x0001. Less 0x0001 vs 0xFFFF -> rsp_f = 0x0000, zero = 1. Equal 0x1234 vs 0x1234 -> rsp_f = 0x0001, over = cout = 0.
- Xor 0xA5A5 ^ 0xFFFF -> rsp_f = 0x5A5A. Not a on 0xFFFF -> rsp_f = 0x0000, zero = 1. Both must take the same latency as add.
- Backpressure: hold rsp_ready low for 3 cycles in DONE, with req_valid high throughout -> rsp_f and flags stable, req_ready = 0, busy = 1. After rsp_ready = 1 for one edge -> IDLE; the next request is accepted on the following edge.
- Pull rst_n low asynchronously during RUN at idx = 2 -> outputs clear immediately, no rsp_valid is ever produced; after release, req_ready = 1 and a fresh add 0x0001 + 0x0001 returns 0x0002.
